// File: rtl/button_pkg.sv
// button_pkg: shared types and default parameter values for the button bank.
// The hold/auto-repeat logic is only built when BUTTON_BANK_HOLD_EN is defined.
package button_pkg;

  // Per-channel hold/auto-repeat FSM states
  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_WAIT   = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_t;

  // Default configuration
  localparam int DEF_N            = 4;
  localparam int DEF_DB_BITS      = 3;
  localparam int DEF_HOLD_TICKS   = 64;
  localparam int DEF_REPEAT_TICKS = 16;

endpackage

// File: rtl/button_bank_if.sv
// button_bank_if: groups the per-channel button pins and the conditioned
// outputs of the button bank. The slave modport is the conditioner side.
interface button_bank_if
  import button_pkg::*;
#(
  parameter int N = DEF_N
);

  logic [N-1:0] btn_i;
  logic [N-1:0] level_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;
  logic [N-1:0] hold_o;

  modport master (
    output btn_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  hold_o
  );

  modport slave (
    input  btn_i,
    output level_o,
    output press_o,
    output release_o,
    output hold_o
  );

endinterface

// File: rtl/button_chan.sv
// button_chan: one button channel -- 2-flop synchroniser, symmetric tick-based
// debounce, registered press/release pulses and, when BUTTON_BANK_HOLD_EN is
// defined, a hold/auto-repeat FSM. Without the macro o_hold is constant 0.
module button_chan
  import button_pkg::*;
#(
  parameter int DB_BITS      = DEF_DB_BITS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam logic [DB_BITS-1:0] CNT_MAX = {DB_BITS{1'b1}};

  logic [1:0]         r_sync;
  logic [DB_BITS-1:0] r_cnt;
  logic               r_st;
  logic               r_press;
  logic               r_release;

  logic w_s;
  logic w_differ;
  logic w_flip;
  logic w_rise;
  logic w_fall;

  // w_flip marks the tick edge on which the stable state takes the new value
  assign w_s      = r_sync[1];
  assign w_differ = i_tick & (w_s ^ r_st);
  assign w_flip   = w_differ & (r_cnt == CNT_MAX);
  assign w_rise   = w_flip & w_s;
  assign w_fall   = w_flip & ~w_s;

  // Synchroniser, debounce counter, stable state and edge pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= 2'b00;
      r_cnt     <= '0;
      r_st      <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_press   <= w_rise;
      r_release <= w_fall;
      if (i_tick) begin
        if (w_s == r_st) begin
          r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + {{(DB_BITS-1){1'b0}}, 1'b1};
        end else begin
          r_st  <= w_s;
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_level   = r_st;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BUTTON_BANK_HOLD_EN
  localparam int HC_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HC_W   = $clog2(HC_MAX + 1);
  // hc counts ticks already seen, so the pulse fires when the last one arrives
  localparam logic [HC_W-1:0] HOLD_LAST   = HC_W'(HOLD_TICKS - 1);
  localparam logic [HC_W-1:0] REPEAT_LAST = HC_W'((REPEAT_TICKS > 0) ? (REPEAT_TICKS - 1) : 0);

  hold_state_t     r_state;
  logic [HC_W-1:0] r_hc;
  logic            r_hold;

  // Hold FSM: release wins over any pending hold pulse on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HOLD_IDLE;
      r_hc    <= '0;
      r_hold  <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      if (w_fall) begin
        r_state <= HOLD_IDLE;
        r_hc    <= '0;
      end else begin
        case (r_state)
          HOLD_IDLE: begin
            if (w_rise) begin
              r_state <= HOLD_WAIT;
              r_hc    <= '0;
            end
          end
          HOLD_WAIT: begin
            if (i_tick) begin
              if (r_hc == HOLD_LAST) begin
                r_hold  <= 1'b1;
                r_hc    <= '0;
                r_state <= (REPEAT_TICKS == 0) ? HOLD_IDLE : HOLD_REPEAT;
              end else begin
                r_hc <= r_hc + HC_W'(1);
              end
            end
          end
          HOLD_REPEAT: begin
            if (i_tick) begin
              if (r_hc == REPEAT_LAST) begin
                r_hold <= 1'b1;
                r_hc   <= '0;
              end else begin
                r_hc <= r_hc + HC_W'(1);
              end
            end
          end
          default: begin
            r_state <= HOLD_IDLE;
            r_hc    <= '0;
          end
        endcase
      end
    end
  end

  assign o_hold = r_hold;
`else
  // Hold timing parameters have no effect in this build
  logic w_unused_hold_cfg;
  assign w_unused_hold_cfg = (HOLD_TICKS != 0) | (REPEAT_TICKS != 0);
  assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/button_bank.sv
// button_bank: N independent button conditioners sharing clk, reset and the
// sample tick. Define BUTTON_BANK_HOLD_EN to build the hold/auto-repeat logic;
// otherwise hold_o is tied to 0.
module button_bank
  import button_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int DB_BITS      = DEF_DB_BITS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  button_bank_if.slave bus
);

  logic [N-1:0] w_level;
  logic [N-1:0] w_press;
  logic [N-1:0] w_release;
  logic [N-1:0] w_hold;

  for (genvar g = 0; g < N; g++) begin : g_chan
    button_chan #(
      .DB_BITS      (DB_BITS),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (tick),
      .i_btn     (bus.btn_i[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_hold    (w_hold[g])
    );
  end

  assign bus.level_o   = w_level;
  assign bus.press_o   = w_press;
  assign bus.release_o = w_release;
  assign bus.hold_o    = w_hold;

endmodule
